// File: rtl/md_sequencer_if.sv
// Bundles the E-stage command, its operands and the sequencer's results.
// The master side is the pipeline; the slave side is the multiply/divide sequencer.
interface md_sequencer_if;
  logic [3:0]  HILO_type;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        D_md_use;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_out;
  logic        MD_stall;

  modport master (
    output HILO_type, A, B, Req, D_md_use,
    input  Start, Busy, HI, LO, MD_out, MD_stall
  );

  modport slave (
    input  HILO_type, A, B, Req, D_md_use,
    output Start, Busy, HI, LO, MD_out, MD_stall
  );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage. It owns HI/LO and computes the
// mult/div result when an op starts. It holds that result for a fixed busy
// window, then commits it to HI/LO. mthi/mtlo write HI/LO directly.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  localparam logic [3:0] CMD_MULT  = 4'd1;
  localparam logic [3:0] CMD_MULTU = 4'd2;
  localparam logic [3:0] CMD_DIV   = 4'd3;
  localparam logic [3:0] CMD_DIVU  = 4'd4;
  localparam logic [3:0] CMD_MFLO  = 4'd5;
  localparam logic [3:0] CMD_MFHI  = 4'd6;
  localparam logic [3:0] CMD_MTLO  = 4'd7;
  localparam logic [3:0] CMD_MTHI  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_we_q, res_we_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic is_mult, is_div, is_md, busy, start;

  assign is_mult = (md.HILO_type == CMD_MULT) || (md.HILO_type == CMD_MULTU);
  assign is_div  = (md.HILO_type == CMD_DIV)  || (md.HILO_type == CMD_DIVU);
  assign is_md   = is_mult || is_div;
  assign busy    = (state_q == RUN);
  assign start   = is_md && !busy && !md.Req;

  // Arithmetic. The divide works on magnitudes and then fixes the signs. This
  // gives truncation toward zero with the remainder taking the sign of A.
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0. A zero divisor is
  // replaced by 1 so the divider never sees 0. That result is never committed.
  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        den, a_mag, b_mag, uq, ur, quo, rem;
  logic               a_neg, b_neg;

  assign a_sx   = {{32{md.A[31]}}, md.A};
  assign b_sx   = {{32{md.B[31]}}, md.B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  assign den   = (md.B == 32'd0) ? 32'd1 : md.B;
  assign a_neg = (md.HILO_type == CMD_DIV) && md.A[31];
  assign b_neg = (md.HILO_type == CMD_DIV) && den[31];
  assign a_mag = a_neg ? (32'd0 - md.A) : md.A;
  assign b_mag = b_neg ? (32'd0 - den) : den;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem   = a_neg ? (32'd0 - ur) : ur;

  // Next-state logic: start an op, count down the busy window and commit,
  // or service mthi/mtlo when idle and not flushed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = res_we_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_mult ? MULT_LOAD : DIV_LOAD;
          if (md.HILO_type == CMD_MULT) begin
            {res_hi_d, res_lo_d} = prod_s;
          end else if (md.HILO_type == CMD_MULTU) begin
            {res_hi_d, res_lo_d} = prod_u;
          end else begin
            res_hi_d = rem;
            res_lo_d = quo;
          end
          // A divide by zero still runs its full window but leaves HI/LO alone.
          res_we_d = !(is_div && (md.B == 32'd0));
        end else if (!md.Req) begin
          if (md.HILO_type == CMD_MTLO) lo_d = md.A;
          if (md.HILO_type == CMD_MTHI) hi_d = md.A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (res_we_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any op in flight and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_we_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_we_q <= res_we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md.Start    = start;
  assign md.Busy     = busy;
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.MD_out   = (md.HILO_type == CMD_MFHI) ? hi_q :
                       (md.HILO_type == CMD_MFLO) ? lo_q : 32'd0;
  assign md.MD_stall = md.D_md_use && (start || busy);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer. A reference model tracks HI/LO and the busy
// window in plain arithmetic. It is compared against every output on each
// falling edge. A few literal expectations pin the model to known answers.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  md_sequencer_if md_if ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(rst),
    .md   (md_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%08h exp=%08h", name, cyc, got, exp);
    end
  endtask

  // Reference result {HI,LO} for an md op, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] md_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (c)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: if (b != 0) begin
              q = sa / sb;
              r = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      4'd4: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Model state: architectural HI/LO, busy cycles left, pending result.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pwe = 0;
  int          m_left = 0;

  // Compare process: check all outputs, then advance the model over the coming edge.
  always @(negedge clk) begin
    logic [3:0]  c;
    logic        e_busy, e_start, e_stall, is_md;
    logic [31:0] e_out;
    c       = md_if.HILO_type;
    is_md   = (c >= 4'd1) && (c <= 4'd4);
    e_busy  = (m_left > 0);
    e_start = is_md && !e_busy && !md_if.Req;
    e_out   = (c == 4'd6) ? m_hi : (c == 4'd5) ? m_lo : 32'd0;
    e_stall = md_if.D_md_use && (e_start || e_busy);
    if (chk_en) begin
      chk("Start",    {31'd0, md_if.Start},    {31'd0, e_start});
      chk("Busy",     {31'd0, md_if.Busy},     {31'd0, e_busy});
      chk("MD_stall", {31'd0, md_if.MD_stall}, {31'd0, e_stall});
      chk("MD_out",   md_if.MD_out, e_out);
      chk("HI",       md_if.HI, m_hi);
      chk("LO",       md_if.LO, m_lo);
    end
    if (rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwe) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (e_start) begin
      {m_phi, m_plo} = md_ref(c, md_if.A, md_if.B);
      m_pwe  = !((c >= 4'd3) && (md_if.B == 32'd0));
      m_left = (c <= 4'd2) ? 5 : 10;
    end else if (!md_if.Req) begin
      if (c == 4'd7) m_lo = md_if.A;
      if (c == 4'd8) m_hi = md_if.A;
    end
    cyc++;
  end

  task automatic step(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic r, input logic d, input logic rs);
    @(posedge clk);
    #1;
    md_if.HILO_type = c;
    md_if.A         = a;
    md_if.B         = b;
    md_if.Req       = r;
    md_if.D_md_use  = d;
    rst             = rs;
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0, d, 1'b0);
  endtask

  task automatic op(input string name, input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic r, input logic d);
    step(c, a, b, r, d, 1'b0);
    $display("cyc=%0d %s A=%08h B=%08h Req=%0b D_md_use=%0b", cyc, name, a, b, r, d);
  endtask

  initial begin
    md_if.HILO_type = 4'd0;
    md_if.A = 32'd0;
    md_if.B = 32'd0;
    md_if.Req = 1'b0;
    md_if.D_md_use = 1'b0;
    step(4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_busy", {31'd0, md_if.Busy}, 32'd0);
    chk("rst_hi", md_if.HI, 32'd0);
    chk("rst_lo", md_if.LO, 32'd0);

    op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    #1; chk("mult_start", {31'd0, md_if.Start}, 32'd1);
    idle(6, 1'b0);
    chk("mult_hi", md_if.HI, 32'hFFFFFFFF);
    chk("mult_lo", md_if.LO, 32'hFFFFFFFE);

    op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("multu_hi", md_if.HI, 32'h00000001);
    chk("multu_lo", md_if.LO, 32'hFFFFFFFE);

    op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    idle(11, 1'b0);
    chk("div_lo", md_if.LO, 32'hFFFFFFFD);
    chk("div_hi", md_if.HI, 32'hFFFFFFFF);

    op("divu", 4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    idle(11, 1'b0);
    chk("divu_lo", md_if.LO, 32'd3);
    chk("divu_hi", md_if.HI, 32'd1);

    op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle(11, 1'b0);
    chk("ovf_lo", md_if.LO, 32'h80000000);
    chk("ovf_hi", md_if.HI, 32'd0);

    op("mthi", 4'd8, 32'h12345678, 32'd0, 1'b0, 1'b0);
    op("mfhi", 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    #1; chk("mfhi_out", md_if.MD_out, 32'h12345678);
    op("div_by_zero", 4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    idle(11, 1'b0);
    chk("dz_hi", md_if.HI, 32'h12345678);

    op("mult_req", 4'd1, 32'd5, 32'd5, 1'b1, 1'b0);
    #1; chk("req_start", {31'd0, md_if.Start}, 32'd0);
    op("mtlo_req", 4'd7, 32'hABCDEF01, 32'd0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("req_busy", {31'd0, md_if.Busy}, 32'd0);
    chk("req_lo", md_if.LO, 32'h80000000);

    op("mult_b2b_1", 4'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    idle(5, 1'b0);
    op("mult_b2b_2", 4'd1, 32'd4, 32'd5, 1'b0, 1'b0);
    #1; chk("b2b_start", {31'd0, md_if.Start}, 32'd1);
    chk("b2b_lo1", md_if.LO, 32'd6);
    idle(6, 1'b0);
    chk("b2b_lo2", md_if.LO, 32'd20);

    op("mult_stall", 4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    op("mtlo_busy", 4'd7, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    op("div_busy", 4'd3, 32'd9, 32'd3, 1'b0, 1'b1);
    op("mflo_busy", 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    #1; chk("mflo_busy_out", md_if.MD_out, 32'd20);
    idle(3, 1'b1);
    #1; chk("stall_release", {31'd0, md_if.MD_stall}, 32'd0);
    chk("stall_lo", md_if.LO, 32'd12);
    idle(1, 1'b0);

    for (int k = 9; k < 16; k++) begin
      logic [3:0] kc;
      kc = 4'(k);
      op("undef_cmd", kc, 32'h55AA55AA, 32'd1, 1'b0, 1'b1);
    end
    idle(1, 1'b0);

    op("div_then_reset", 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst_busy", {31'd0, md_if.Busy}, 32'd0);
    chk("midrst_hi", md_if.HI, 32'd0);
    chk("midrst_lo", md_if.LO, 32'd0);
    op("mult_after_rst", 4'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("after_rst_lo", md_if.LO, 32'd42);
    chk("after_rst_hi", md_if.HI, 32'd0);

    op("mult_neg", 4'd1, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    idle(6, 1'b0);
    op("divu_big", 4'd4, 32'hFFFFFFFF, 32'd16, 1'b0, 1'b0);
    idle(11, 1'b0);
    op("div_pos_neg", 4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    idle(12, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
